// File: rtl/n64_vi_demux_pkg.sv
// rtl/n64_vi_demux_pkg.sv - shared widths, sync bit indices and phase encodings for the VI demux
package n64_vi_demux_pkg;

  // Colour channel width on the VI bus and in the packed pixel word
  localparam int COLOR_W = 7;
  localparam int VDATA_W = 3*COLOR_W + 4;

  // Sync nibble bit positions (active-low syncs)
  localparam int SYNC_NVSYNC = 3;
  localparam int SYNC_NCLAMP = 2;
  localparam int SYNC_NHSYNC = 1;
  localparam int SYNC_NCSYNC = 0;

  // All syncs inactive
  localparam logic [3:0] SYNC_IDLE = 4'hF;

  // Field length above which the source is PAL
  localparam logic [8:0] PAL_LINE_THRESH = 9'd288;
  localparam logic [8:0] LINE_CNT_MAX    = 9'h1FF;

  // Bus phase: which word the next nDSYNC-high cycle carries
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_R    = 2'd1,
    PH_G    = 2'd2,
    PH_B    = 2'd3
  } phase_t;

endpackage

// File: rtl/n64_vi_format_detect.sv
// rtl/n64_vi_format_detect.sv - line counting and PAL / interlace detection on the assembled pixel stream
module n64_vi_format_detect
  import n64_vi_demux_pkg::*;
(
  input  logic       VCLK,
  input  logic       nRST,
  input  logic       vdata_valid,
  input  logic [3:0] sync,
  output logic       palmode_o,
  output logic       n64_480i_o
);

  logic       prev_nvsync;
  logic       prev_nhsync;
  logic [8:0] line_cnt;
  logic [8:0] prev_line_cnt;
  logic       field_seen;
  logic       hs_fall;
  logic       vs_fall;
  logic       unused_sync;

  // Clamp and composite sync carry no field-format information
  assign unused_sync = &{1'b0, sync[SYNC_NCLAMP], sync[SYNC_NCSYNC]};

  // Edges are only meaningful on strobe cycles, against the previous pixel's syncs
  assign hs_fall = vdata_valid & prev_nhsync & ~sync[SYNC_NHSYNC];
  assign vs_fall = vdata_valid & prev_nvsync & ~sync[SYNC_NVSYNC];

  // Count lines per field; a vsync edge closes the field and takes priority over hsync
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      prev_nvsync   <= 1'b1;
      prev_nhsync   <= 1'b1;
      line_cnt      <= 9'd0;
      prev_line_cnt <= 9'd0;
      field_seen    <= 1'b0;
      palmode_o     <= 1'b0;
      n64_480i_o    <= 1'b0;
    end else if (vdata_valid) begin
      prev_nvsync <= sync[SYNC_NVSYNC];
      prev_nhsync <= sync[SYNC_NHSYNC];
      if (vs_fall) begin
        // The partial field before the first vsync only seeds the comparison
        if (field_seen) begin
          palmode_o  <= (line_cnt > PAL_LINE_THRESH);
          n64_480i_o <= (line_cnt != prev_line_cnt);
        end
        field_seen    <= 1'b1;
        prev_line_cnt <= line_cnt;
        line_cnt      <= 9'd0;
      end else if (hs_fall && (line_cnt != LINE_CNT_MAX)) begin
        line_cnt <= line_cnt + 9'd1;
      end
    end
  end

endmodule

// File: rtl/n64_vi_demux.sv
// rtl/n64_vi_demux.sv - VI bus sampler assembling sync+RGB pixel words with a valid strobe
module n64_vi_demux
  import n64_vi_demux_pkg::*;
(
  input  logic               VCLK,
  input  logic               nRST,
  input  logic               nDSYNC,
  input  logic [COLOR_W-1:0] D_i,
  output logic               vdata_valid_o,
  output logic [VDATA_W-1:0] vdata_o,
  output logic               palmode_o,
  output logic               n64_480i_o,
  output logic               desync_o
);

  phase_t             phase;
  logic [3:0]         sync_sh;
  logic [COLOR_W-1:0] red_sh;
  logic [COLOR_W-1:0] grn_sh;
  logic [COLOR_W-1:0] blu_sh;
  logic               px_pend;

  // Phase FSM: nDSYNC low always restarts a pixel; an interrupted G/B phase is a desync
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      phase    <= PH_IDLE;
      sync_sh  <= 4'd0;
      red_sh   <= '0;
      grn_sh   <= '0;
      blu_sh   <= '0;
      px_pend  <= 1'b0;
      desync_o <= 1'b0;
    end else begin
      px_pend <= 1'b0;
      if (!nDSYNC) begin
        sync_sh <= D_i[3:0];
        phase   <= PH_R;
        if ((phase == PH_G) || (phase == PH_B)) begin
          desync_o <= 1'b1;
        end
      end else begin
        case (phase)
          PH_R: begin
            red_sh <= D_i;
            phase  <= PH_G;
          end
          PH_G: begin
            grn_sh <= D_i;
            phase  <= PH_B;
          end
          PH_B: begin
            blu_sh  <= D_i;
            phase   <= PH_IDLE;
            px_pend <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Publish the completed pixel one cycle after the blue sample; hold between strobes
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      vdata_valid_o <= 1'b0;
      vdata_o       <= {SYNC_IDLE, {(3*COLOR_W){1'b0}}};
    end else begin
      vdata_valid_o <= px_pend;
      if (px_pend) begin
        vdata_o <= {sync_sh, red_sh, grn_sh, blu_sh};
      end
    end
  end

  n64_vi_format_detect u_fmt (
    .VCLK        (VCLK),
    .nRST        (nRST),
    .vdata_valid (vdata_valid_o),
    .sync        (vdata_o[VDATA_W-1 -: 4]),
    .palmode_o   (palmode_o),
    .n64_480i_o  (n64_480i_o)
  );

endmodule

// File: tb/tb_n64_vi_demux.sv
// tb/tb_n64_vi_demux.sv - directed self-checking bench for n64_vi_demux
`timescale 1ns/1ps
module tb_n64_vi_demux;
  import n64_vi_demux_pkg::*;

  logic               VCLK = 1'b0;
  logic               nRST;
  logic               nDSYNC;
  logic [COLOR_W-1:0] D_i;
  logic               vdata_valid_o;
  logic [VDATA_W-1:0] vdata_o;
  logic               palmode_o;
  logic               n64_480i_o;
  logic               desync_o;

  int total  = 0;
  int passed = 0;

  logic [VDATA_W-1:0] rst_word;

  n64_vi_demux dut (
    .VCLK          (VCLK),
    .nRST          (nRST),
    .nDSYNC        (nDSYNC),
    .D_i           (D_i),
    .vdata_valid_o (vdata_valid_o),
    .vdata_o       (vdata_o),
    .palmode_o     (palmode_o),
    .n64_480i_o    (n64_480i_o),
    .desync_o      (desync_o)
  );

  always #5 VCLK = ~VCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge VCLK);
    #1;
  endtask

  task automatic send_sync(input logic [3:0] s);
    nDSYNC = 1'b0;
    D_i    = {3'b000, s};
    tick();
  endtask

  task automatic send_word(input logic [COLOR_W-1:0] w);
    nDSYNC = 1'b1;
    D_i    = w;
    tick();
  endtask

  task automatic send_pixel(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
    send_sync(s);
    send_word(r);
    send_word(g);
    send_word(b);
  endtask

  // One line: a pixel with nHSYNC low followed by one with all syncs idle
  task automatic send_line();
    send_pixel(4'hD, 7'h01, 7'h02, 7'h03);
    send_pixel(4'hF, 7'h04, 7'h05, 7'h06);
  endtask

  task automatic send_vsync();
    send_pixel(4'h7, 7'h00, 7'h00, 7'h00);
    send_pixel(4'hF, 7'h00, 7'h00, 7'h00);
  endtask

  task automatic send_field(input int n);
    repeat (n) send_line();
    send_vsync();
  endtask

  task automatic pulse_reset();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
  endtask

  initial begin
    rst_word = {4'hF, 21'h0};
    nRST   = 1'b0;
    nDSYNC = 1'b1;
    D_i    = '0;
    tick();
    tick();
    check("rst_valid",   vdata_valid_o, 0);
    check("rst_vdata",   vdata_o, rst_word);
    check("rst_palmode", palmode_o, 0);
    check("rst_480i",    n64_480i_o, 0);
    check("rst_desync",  desync_o, 0);
    nRST = 1'b1;
    tick();

    // Basic pixel assembly and one-cycle strobe
    send_pixel(4'hF, 7'h11, 7'h22, 7'h33);
    nDSYNC = 1'b1;
    check("px_latency_valid", vdata_valid_o, 0);
    tick();
    check("px_valid", vdata_valid_o, 1);
    check("px_vdata", vdata_o, {4'hF, 7'h11, 7'h22, 7'h33});
    tick();
    check("px_valid_drop", vdata_valid_o, 0);
    check("px_vdata_hold", vdata_o, {4'hF, 7'h11, 7'h22, 7'h33});

    // Two consecutive sync cycles: later nibble wins, not a desync
    send_sync(4'hD);
    send_sync(4'hF);
    check("dbl_sync_desync", desync_o, 0);
    send_word(7'h01);
    send_word(7'h02);
    send_word(7'h03);
    tick();
    check("dbl_sync_valid",  vdata_valid_o, 1);
    check("dbl_sync_vdata",  vdata_o, {4'hF, 7'h01, 7'h02, 7'h03});
    check("dbl_sync_desync2", desync_o, 0);

    // Early resync in B aborts the pixel
    send_sync(4'hF);
    send_word(7'h11);
    send_word(7'h22);
    send_sync(4'hF);
    check("resync_desync", desync_o, 1);
    check("resync_nostrobe", vdata_valid_o, 0);
    send_word(7'h44);
    send_word(7'h55);
    send_word(7'h66);
    nDSYNC = 1'b1;
    check("resync_nostrobe2", vdata_valid_o, 0);
    tick();
    check("resync_valid", vdata_valid_o, 1);
    check("resync_vdata", vdata_o, {4'hF, 7'h44, 7'h55, 7'h66});
    tick();
    check("resync_sticky", desync_o, 1);

    // Reset asserted while the FSM is in G
    send_sync(4'hF);
    send_word(7'h77);
    nRST = 1'b0;
    #1;
    check("midrst_vdata",  vdata_o, rst_word);
    check("midrst_desync", desync_o, 0);
    check("midrst_valid",  vdata_valid_o, 0);
    nRST = 1'b1;
    send_word(7'h12);
    send_word(7'h34);
    tick();
    check("midrst_nostrobe", vdata_valid_o, 0);
    send_pixel(4'hF, 7'h0A, 7'h0B, 7'h0C);
    nDSYNC = 1'b1;
    tick();
    check("midrst_valid_after", vdata_valid_o, 1);
    check("midrst_vdata_after", vdata_o, {4'hF, 7'h0A, 7'h0B, 7'h0C});

    // NTSC progressive: 263-line fields
    pulse_reset();
    send_field(263);
    check("ntsc_v1_pal",  palmode_o, 0);
    check("ntsc_v1_480i", n64_480i_o, 0);
    send_field(263);
    check("ntsc_v2_pal",  palmode_o, 0);
    check("ntsc_v2_480i", n64_480i_o, 0);
    send_field(263);
    check("ntsc_v3_pal",  palmode_o, 0);
    check("ntsc_v3_480i", n64_480i_o, 0);

    // PAL interlaced: 312/313 alternating
    pulse_reset();
    send_field(312);
    check("pal_v1_pal",  palmode_o, 0);
    check("pal_v1_480i", n64_480i_o, 0);
    send_field(313);
    send_field(312);
    check("pal_v3_pal",  palmode_o, 1);
    check("pal_v3_480i", n64_480i_o, 1);
    send_field(313);
    check("pal_v4_pal",  palmode_o, 1);
    check("pal_v4_480i", n64_480i_o, 1);

    // Line counter saturation
    pulse_reset();
    send_field(10);
    repeat (600) send_line();
    tick();
    check("sat_line_cnt", dut.u_fmt.line_cnt, 9'h1FF);
    send_vsync();
    check("sat_pal",      palmode_o, 1);
    check("sat_line_clr", dut.u_fmt.line_cnt, 0);

    // Simultaneous vsync and hsync edges: vsync action wins
    repeat (3) send_line();
    send_pixel(4'h5, 7'h00, 7'h00, 7'h00);
    send_pixel(4'hF, 7'h00, 7'h00, 7'h00);
    nDSYNC = 1'b1;
    tick();
    check("simul_line_cnt", dut.u_fmt.line_cnt, 0);
    check("simul_pal",      palmode_o, 0);
    check("simul_480i",     n64_480i_o, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
